// File: rtl/fc_pkg.sv
// Shared state encoding and checksum configuration for the FC parameter loader.
// Defining FC_LOADER_CHECKSUM_EN adds the trailing checksum beat and the CHECK state.
package fc_pkg;

`ifdef FC_LOADER_CHECKSUM_EN
  localparam bit ChecksumEn = 1'b1;
`else
  localparam bit ChecksumEn = 1'b0;
`endif

  localparam int unsigned StateWidth = 3;

  typedef enum logic [StateWidth-1:0] {
    StIdle    = 3'd0,
    StWeights = 3'd1,
    StBiases  = 3'd2,
`ifdef FC_LOADER_CHECKSUM_EN
    StCheck   = 3'd3,
`endif
    StCommit  = 3'd4
  } fc_state_e;

endpackage

// File: rtl/fc_beat_counter.sv
// Beat counter for one load phase; flags the final beat of the phase against a runtime limit.
module fc_beat_counter #(
  parameter int unsigned CntWidth = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                inc,
  input  logic [CntWidth-1:0] limit,
  output logic [CntWidth-1:0] count,
  output logic                last
);

  logic [CntWidth-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + CntWidth'(1);
    end
  end

  assign count = count_q;
  assign last  = (count_q == limit - CntWidth'(1));

endmodule

// File: rtl/fc_param_loader.sv
// Streams FC layer weights then biases into flat images and strobes a commit.
// Optional FC_LOADER_CHECKSUM_EN: one extra beat must equal the modulo sum of all beats.
module fc_param_loader
  import fc_pkg::*;
#(
  parameter int unsigned INPUT_SIZE  = 16,
  parameter int unsigned OUTPUT_SIZE = 4,
  parameter int unsigned ACTIV_BITS  = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      abort,
  input  logic                                      s_valid,
  input  logic [ACTIV_BITS-1:0]                     s_data,
  output logic                                      s_ready,
  output logic [OUTPUT_SIZE*INPUT_SIZE*ACTIV_BITS-1:0] weights_out,
  output logic [OUTPUT_SIZE*ACTIV_BITS-1:0]         biases_out,
  output logic                                      load_weights,
  output logic                                      load_biases,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err
);

  localparam int unsigned NumWeights = OUTPUT_SIZE * INPUT_SIZE;
  localparam int unsigned CntWidth   = $clog2(NumWeights + 1);

  fc_state_e state_q;
  logic [NumWeights*ACTIV_BITS-1:0]  weights_q;
  logic [OUTPUT_SIZE*ACTIV_BITS-1:0] biases_q;

  logic                accept;
  logic                cnt_inc;
  logic                cnt_clear;
  logic                cnt_last;
  logic [CntWidth-1:0] cnt;
  logic [CntWidth-1:0] cnt_limit;

`ifdef FC_LOADER_CHECKSUM_EN
  logic [ACTIV_BITS-1:0] sum_q;
  logic                  err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy         = (state_q != StIdle);
  assign s_ready      = busy && (state_q != StCommit);
  assign load_weights = (state_q == StCommit);
  assign load_biases  = (state_q == StCommit);
  assign done         = (state_q == StCommit);
  assign weights_out  = weights_q;
  assign biases_out   = biases_q;

  assign accept    = s_valid && s_ready;
  assign cnt_inc   = accept && !abort && ((state_q == StWeights) || (state_q == StBiases));
  // Clearing while idle guarantees every session starts counting from zero.
  assign cnt_clear = (state_q == StIdle) || abort || (cnt_inc && cnt_last);
  assign cnt_limit = (state_q == StWeights) ? CntWidth'(NumWeights) : CntWidth'(OUTPUT_SIZE);

  fc_beat_counter #(
    .CntWidth (CntWidth)
  ) u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .limit (cnt_limit),
    .count (cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      weights_q <= '0;
      biases_q  <= '0;
`ifdef FC_LOADER_CHECKSUM_EN
      sum_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else if (abort && (state_q != StIdle)) begin
      // Abort wins over a same-cycle beat; images keep whatever was already written.
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StWeights;
`ifdef FC_LOADER_CHECKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
          end
        end
        StWeights: begin
          if (accept) begin
            weights_q[int'(cnt)*ACTIV_BITS +: ACTIV_BITS] <= s_data;
`ifdef FC_LOADER_CHECKSUM_EN
            sum_q <= sum_q + s_data;
`endif
            if (cnt_last) state_q <= StBiases;
          end
        end
        StBiases: begin
          if (accept) begin
            biases_q[int'(cnt)*ACTIV_BITS +: ACTIV_BITS] <= s_data;
`ifdef FC_LOADER_CHECKSUM_EN
            sum_q <= sum_q + s_data;
            if (cnt_last) state_q <= StCheck;
`else
            if (cnt_last) state_q <= StCommit;
`endif
          end
        end
`ifdef FC_LOADER_CHECKSUM_EN
        StCheck: begin
          if (accept) begin
            if (s_data == sum_q) begin
              state_q <= StCommit;
            end else begin
              state_q <= StIdle;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        StCommit: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_param_loader.sv
// Self-checking bench for fc_param_loader (4 inputs, 2 outputs, 8-bit beats) against a
// session-level model; honours FC_LOADER_CHECKSUM_EN when defined.
module tb_fc_param_loader;

  localparam int NW = 8;
  localparam int NB = 2;
`ifdef FC_LOADER_CHECKSUM_EN
  localparam int CkBeats = 1;
`else
  localparam int CkBeats = 0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [63:0] weights_out;
  logic [15:0] biases_out;
  logic        load_weights;
  logic        load_biases;
  logic        busy;
  logic        done;
  logic        err;

  fc_param_loader #(
    .INPUT_SIZE  (4),
    .OUTPUT_SIZE (2),
    .ACTIV_BITS  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .weights_out  (weights_out),
    .biases_out   (biases_out),
    .load_weights (load_weights),
    .load_biases  (load_biases),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_strobe = 0;
  bit cmp_en = 1'b0;

  // Session-level model: whether a session is open, how many beats it has taken,
  // and whether this cycle is the commit cycle.
  bit       m_active;
  bit       m_commit;
  int       m_n;
  bit       m_err;
  bit [7:0] m_sum;
  bit [7:0] m_w [NW];
  bit [7:0] m_b [NB];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input logic r, input logic st, input logic ab, input logic v,
                            input logic [7:0] d);
    if (r) begin
      m_active = 0; m_commit = 0; m_n = 0; m_err = 0; m_sum = 0;
      for (int i = 0; i < NW; i++) m_w[i] = 0;
      for (int i = 0; i < NB; i++) m_b[i] = 0;
    end else if (m_active && ab) begin
      m_active = 0; m_commit = 0;
    end else if (m_commit) begin
      m_commit = 0; m_active = 0;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1; m_n = 0; m_err = 0; m_sum = 0;
      end
    end else if (v) begin
      if (m_n < NW) begin
        m_w[m_n] = d; m_sum += d;
      end else if (m_n < NW + NB) begin
        m_b[m_n - NW] = d; m_sum += d;
      end
      m_n++;
      if (m_n == NW + NB && CkBeats == 0) begin
        m_commit = 1;
      end else if (m_n == NW + NB + 1) begin
        if (d == m_sum) m_commit = 1;
        else begin m_active = 0; m_err = 1; end
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [63:0] exp_w;
      logic [15:0] exp_b;
      for (int i = 0; i < NW; i++) exp_w[i*8 +: 8] = m_w[i];
      for (int i = 0; i < NB; i++) exp_b[i*8 +: 8] = m_b[i];
      check("busy", 64'(busy), 64'(m_active));
      check("s_ready", 64'(s_ready), 64'(m_active && !m_commit));
      check("load_weights", 64'(load_weights), 64'(m_commit));
      check("load_biases", 64'(load_biases), 64'(m_commit));
      check("done", 64'(done), 64'(m_commit));
      check("err", 64'(err), 64'(m_err));
      check("weights_out", weights_out, exp_w);
      check("biases_out", 64'(biases_out), 64'(exp_b));
      if (done) n_strobe++;
    end
  end

  task automatic step(input logic r, input logic st, input logic ab, input logic v,
                      input logic [7:0] d);
    rst = r; start = st; abort = ab; s_valid = v; s_data = d;
    @(posedge clk);
    model_step(r, st, ab, v, d);
    @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] base, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap) step(0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 1, base + 8'(i));
    end
  endtask

  int s0;

  initial begin
    rst = 1; start = 0; abort = 0; s_valid = 0; s_data = 0;
    step(1, 0, 0, 0, 0);
    cmp_en = 1'b1;
    step(1, 0, 0, 0, 0);
    check("reset_weights", weights_out, 64'h0);
    check("reset_busy", 64'(busy), 64'h0);

    // Back-to-back session.
    s0 = n_strobe;
    step(0, 1, 0, 0, 0);
    send_seq(8'h01, 10, 0);
`ifdef FC_LOADER_CHECKSUM_EN
    step(0, 0, 0, 1, 8'h37);
`endif
    check("b2b_done_pulse", 64'(done), 64'h1);
    step(0, 0, 0, 0, 0);
    check("b2b_done_low", 64'(done), 64'h0);
    step(0, 0, 0, 0, 0);
    check("b2b_weights", weights_out, 64'h0807060504030201);
    check("b2b_biases", 64'(biases_out), 64'h0A09);
    check("b2b_strobes", 64'(n_strobe - s0), 64'd1);

    // Same data with gaps.
    s0 = n_strobe;
    step(0, 1, 0, 0, 0);
    send_seq(8'h01, 10, 1);
`ifdef FC_LOADER_CHECKSUM_EN
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 8'h37);
`endif
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("gap_weights", weights_out, 64'h0807060504030201);
    check("gap_biases", 64'(biases_out), 64'h0A09);
    check("gap_strobes", 64'(n_strobe - s0), 64'd1);

    // Abort after 5 beats; the abort-cycle beat is discarded.
    s0 = n_strobe;
    step(0, 1, 0, 0, 0);
    send_seq(8'h21, 5, 0);
    step(0, 0, 1, 1, 8'hEE);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_strobes", 64'(n_strobe - s0), 64'd0);
    step(0, 1, 0, 0, 0);
    send_seq(8'h11, 10, 0);
`ifdef FC_LOADER_CHECKSUM_EN
    step(0, 0, 0, 1, 8'hD7);
`endif
    step(0, 0, 0, 0, 0);
    check("abort_new_weights", weights_out, 64'h1817161514131211);
    check("abort_new_biases", 64'(biases_out), 64'h1A19);

    // Reset mid-session.
    s0 = n_strobe;
    step(0, 1, 0, 0, 0);
    send_seq(8'h31, 3, 0);
    step(1, 0, 0, 0, 0);
    check("rst_weights", weights_out, 64'h0);
    check("rst_biases", 64'(biases_out), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_strobes", 64'(n_strobe - s0), 64'd0);

`ifdef FC_LOADER_CHECKSUM_EN
    // Bad checksum beat.
    s0 = n_strobe;
    step(0, 1, 0, 0, 0);
    send_seq(8'h01, 10, 0);
    step(0, 0, 0, 1, 8'h38);
    step(0, 0, 0, 0, 0);
    check("ck_err", 64'(err), 64'h1);
    check("ck_strobes", 64'(n_strobe - s0), 64'd0);
    step(0, 1, 0, 0, 0);
    check("ck_err_cleared", 64'(err), 64'h0);
    step(0, 0, 1, 0, 0);
`endif

    // Start pulsed mid-WEIGHTS is ignored and the count continues.
    step(0, 1, 0, 0, 0);
    send_seq(8'h01, 3, 0);
    step(0, 1, 0, 1, 8'h04);
    send_seq(8'h05, 6, 0);
`ifdef FC_LOADER_CHECKSUM_EN
    step(0, 0, 0, 1, 8'h37);
`endif
    check("restart_ign_done", 64'(done), 64'h1);
    step(0, 0, 0, 0, 0);
    check("restart_ign_weights", weights_out, 64'h0807060504030201);
    check("restart_ign_biases", 64'(biases_out), 64'h0A09);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic       r, st, ab, v;
      logic [7:0] d;
      r  = ($urandom_range(0, 299) == 0);
      ab = m_active && ($urandom_range(0, 59) == 0);
      st = ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 9) < 6);
      d  = 8'($urandom);
      if (CkBeats != 0 && m_active && m_n == NW + NB && $urandom_range(0, 1) == 1) d = m_sum;
      step(r, st, ab, v, d);
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
